debug_stream_unit: RTL and testbench
====================================

# debug_stream_unit

Parametrised UART debug controller between the UART (rx/tx) and the MIPS datapath. It decodes single-byte host commands for datapath reset, single-step and continuous run until halt. It snapshots an arbitrary-width datapath debug bus and streams it to the host byte by byte with a tx_start/tx_done_tick handshake. It replaces the fixed 1376-bit, stateless debug unit.

## Interface
- DATA_W, 1376: width of the datapath debug bus; must be a multiple of 8.
- CMD_STEP, 8'h73 ('s'): execute one datapath cycle, then dump.
- CMD_CONT, 8'h63 ('c'): run until halt, then dump.
- CMD_RST, 8'h72 ('r'): reset the datapath.
- RST_CYCLES, 4: length of the Datapath_reset pulse issued by CMD_RST.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe; rx_bus holds a valid command byte.
- rx_bus  in  8  received command byte.
- tx_done_tick  in  1  one-cycle strobe; UART finished the current byte.
- DataPath_bus  in  DATA_W  datapath debug state.
- halt  in  1  datapath has executed HALT; level signal.
- Datapath_clk_en  out  1  datapath clock enable.
- Datapath_reset  out  1  datapath reset.
- tx_start  out  1  one-cycle strobe; start sending tx_bus.
- tx_bus  out  8  byte to transmit.
- busy  out  1  high in every state except IDLE.

## Operation
- NBYTES = DATA_W/8, or DATA_W/8 + 4 with the macro below. The byte counter is $clog2(NBYTES+1) bits wide.
- States: IDLE, RSTP, STEP, RUN, LOAD, SEND, WAIT.
- **IDLE**
  - rx_done_tick with CMD_RST -> RSTP.
  - rx_done_tick with CMD_STEP -> STEP.
  - rx_done_tick with CMD_CONT -> RUN.
  - Any other byte is ignored and the state stays IDLE.
- **RSTP**: Datapath_reset is high for exactly RST_CYCLES cycles, then -> IDLE. No dump follows.
- **STEP**: Datapath_clk_en is high for exactly one cycle -> LOAD.
- **RUN**
  - Datapath_clk_en stays high while halt=0.
  - The first cycle with halt=1 drives Datapath_clk_en=0 that same cycle (combinational gate on halt) -> LOAD.
  - If halt is already 1 on entry, zero datapath cycles run.
- **LOAD**
  - The shift register captures DataPath_bus; byte counter = NBYTES -> SEND.
- **SEND**
  - tx_bus = shift register [7:0], so the least significant byte goes first.
  - tx_start pulses for one cycle -> WAIT.
- **WAIT**: on tx_done_tick,
  - shift register shifts right by 8;
  - counter decrements;
  - if counter reaches 0 -> IDLE, else -> SEND.
- Command bytes (rx_done_tick) arriving in any state other than IDLE are dropped; they are not queued.
- tx_done_tick outside WAIT is ignored.

## Timing
- Reset values: state IDLE, Datapath_clk_en=0, Datapath_reset=1, tx_start=0, tx_bus=0, busy=0, shift register 0.
  - Datapath_reset follows reset and is held while reset=1.
  - Datapath_reset falls in the first cycle after reset deasserts.
- Reset asserted mid-operation (RUN, SEND, WAIT) aborts immediately on the next edge. The remaining bytes are never sent.
- Command to first tx_start:
  - CMD_STEP: 3 cycles (STEP, LOAD, SEND).
  - CMD_CONT: halt observed + 2 cycles.
- tx_bus is registered and stable from the tx_start cycle until the tx_done_tick that completes the byte.
- Gap between consecutive bytes: tx_start occurs 1 cycle after the previous tx_done_tick.
- The dump snapshot is taken in LOAD. Datapath_clk_en is 0 in LOAD/SEND/WAIT, so the bus is static during the dump.
- busy rises the cycle after the accepted command and falls when the state returns to IDLE.

## Configuration
- DEBUG_CYCLE_COUNT_EN defined:
  - A 32-bit counter increments on every cycle with Datapath_clk_en=1.
  - CMD_RST and reset clear it; it wraps from 32'hFFFFFFFF to 0.
  - LOAD appends the counter above DataPath_bus, so NBYTES = DATA_W/8 + 4 and the counter bytes are sent last, LSB first.
- Undefined: no counter; NBYTES = DATA_W/8.

## Test plan
- Reset, then bench at DATA_W=32. Send 'r' -> Datapath_reset high for exactly 4 cycles, busy high meanwhile, no tx_start.
- DataPath_bus=32'hA1B2C3D4, send 's':
  - exactly one Datapath_clk_en cycle;
  - tx_bus bytes D4, C3, B2, A1, each with one tx_start pulse;
  - busy low after the 4th tx_done_tick.
- Send 'c', raise halt after 10 cycles:
  - Datapath_clk_en high for exactly 10 cycles, then a 4-byte dump;
  - with DEBUG_CYCLE_COUNT_EN: 8 bytes, and the last 4 are 0A 00 00 00.
- Send 's' during WAIT, plus a stray tx_done_tick in IDLE -> command ignored, no extra bytes, byte count stays 4.
- Assert reset after the 2nd byte's tx_start -> next cycle in IDLE with tx_start=0 and Datapath_reset=1; no further bytes are sent.
- Send 8'h41 in IDLE -> no state change, busy stays 0.

Source files
------------

// File: rtl/debug_stream_if.sv
// Signal bundle between the UART/datapath environment (master) and debug_stream_unit (slave).
// DATA_W sets the width of the datapath debug bus carried by the bundle.
interface debug_stream_if #(
    parameter int DATA_W = 1376
);
    logic              rx_done_tick;
    logic [7:0]        rx_bus;
    logic              tx_done_tick;
    logic [DATA_W-1:0] DataPath_bus;
    logic              halt;
    logic              Datapath_clk_en;
    logic              Datapath_reset;
    logic              tx_start;
    logic [7:0]        tx_bus;
    logic              busy;

    modport master (
        output rx_done_tick,
        output rx_bus,
        output tx_done_tick,
        output DataPath_bus,
        output halt,
        input  Datapath_clk_en,
        input  Datapath_reset,
        input  tx_start,
        input  tx_bus,
        input  busy
    );

    modport slave (
        input  rx_done_tick,
        input  rx_bus,
        input  tx_done_tick,
        input  DataPath_bus,
        input  halt,
        output Datapath_clk_en,
        output Datapath_reset,
        output tx_start,
        output tx_bus,
        output busy
    );
endinterface

// File: rtl/debug_stream_unit.sv
// UART debug controller: decodes host commands (reset / step / continue) and streams a datapath
// snapshot LSB-first. Define DEBUG_CYCLE_COUNT_EN to append a 32-bit executed-cycle counter.
module debug_stream_unit #(
    parameter int         DATA_W     = 1376,
    parameter logic [7:0] CMD_STEP   = 8'h73,
    parameter logic [7:0] CMD_CONT   = 8'h63,
    parameter logic [7:0] CMD_RST    = 8'h72,
    parameter int         RST_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    debug_stream_if.slave dbg
);

`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int NBYTES = DATA_W / 8 + 4;
`else
    localparam int NBYTES = DATA_W / 8;
`endif
    localparam int SH_W  = NBYTES * 8;
    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSTP,
        ST_STEP,
        ST_RUN,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic              dp_reset_q, dp_reset_d;

    logic [SH_W-1:0]   shift_dn;
    logic [SH_W-1:0]   load_word;
    logic              clk_en;
    logic              cmd_valid;

    assign cmd_valid = (state_q == ST_IDLE) && dbg.rx_done_tick;

    // Byte-lane shifter: each lane takes the next-higher byte, the top lane drains to zero.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            if (gi == NBYTES - 1) begin : g_top
                assign shift_dn[gi*8 +: 8] = 8'h00;
            end else begin : g_mid
                assign shift_dn[gi*8 +: 8] = shift_q[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    // The RUN gate is combinational on halt so the halting cycle itself never clocks the datapath.
    always_comb begin
        clk_en = 1'b0;
        if (state_q == ST_STEP) begin
            clk_en = 1'b1;
        end else if (state_q == ST_RUN) begin
            clk_en = ~dbg.halt;
        end
    end

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (cmd_valid && (dbg.rx_bus == CMD_RST)) begin
            cyc_cnt_d = '0;
        end else if (clk_en) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign load_word = {cyc_cnt_q, dbg.DataPath_bus};
`else
    assign load_word = dbg.DataPath_bus;
`endif

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (dbg.rx_bus == CMD_RST) begin
                        state_d   = ST_RSTP;
                        rst_cnt_d = RC_W'(RST_CYCLES - 1);
                    end else if (dbg.rx_bus == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else if (dbg.rx_bus == CMD_CONT) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RSTP: begin
                if (rst_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (dbg.halt) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d    = load_word;
                byte_cnt_d = CNT_W'(NBYTES);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dbg.tx_done_tick) begin
                    shift_d    = shift_dn;
                    byte_cnt_d = byte_cnt_q - 1'b1;
                    state_d    = (byte_cnt_q == CNT_W'(1)) ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the pulse lines up exactly with the RSTP residency.
        dp_reset_d = (state_d == ST_RSTP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            dp_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            dp_reset_q <= dp_reset_d;
        end
    end

    assign dbg.Datapath_clk_en = clk_en;
    assign dbg.Datapath_reset  = dp_reset_q;
    assign dbg.tx_start        = (state_q == ST_SEND);
    assign dbg.tx_bus          = shift_q[7:0];
    assign dbg.busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_stream_unit.sv
// Directed self-checking bench for debug_stream_unit at DATA_W = 32.
module tb_debug_stream_unit;

    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_RST  = 8'h72;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int NB = 8;
`else
    localparam int NB = 4;
`endif

    logic clk;
    logic reset;

    debug_stream_if #(.DATA_W(32)) dbg ();

    debug_stream_unit #(
        .DATA_W     (32),
        .CMD_STEP   (CMD_STEP),
        .CMD_CONT   (CMD_CONT),
        .CMD_RST    (CMD_RST),
        .RST_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Running totals sampled at the falling edge; tests compare differences.
    int clk_en_tot = 0;
    int dp_rst_tot = 0;
    int busy_tot   = 0;
    int tx_tot     = 0;

    always @(negedge clk) begin
        if (dbg.Datapath_clk_en === 1'b1) clk_en_tot <= clk_en_tot + 1;
        if (dbg.Datapath_reset === 1'b1)  dp_rst_tot <= dp_rst_tot + 1;
        if (dbg.busy === 1'b1)            busy_tot   <= busy_tot + 1;
        if (dbg.tx_start === 1'b1)        tx_tot     <= tx_tot + 1;
    end

    logic [7:0]  got_bytes [8];
    int          got_waits [8];
    int          nfound;
    bit          stable;
    logic [31:0] exp_cyc;

    function automatic logic [7:0] exp_byte(input logic [31:0] data, input logic [31:0] cyc, input int k);
        logic [63:0] w;
        w = {cyc, data};
        return w[k*8 +: 8];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        dbg.rx_bus       = b;
        dbg.rx_done_tick = 1'b1;
        tick(1);
        dbg.rx_done_tick = 1'b0;
        dbg.rx_bus       = 8'h00;
    endtask

    task automatic wait_tx_start(input int budget, output bit ok, output logic [7:0] b, output int waited);
        waited = 0;
        ok = (dbg.tx_start === 1'b1);
        while (!ok && waited < budget) begin
            tick(1);
            waited++;
            ok = (dbg.tx_start === 1'b1);
        end
        b = dbg.tx_bus;
    endtask

    // Plays the UART side for n bytes; optionally injects a step command during the first WAIT.
    task automatic collect_dump(input int n, input bit inject);
        bit         ok;
        logic [7:0] b;
        int         w;
        nfound = 0;
        stable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            got_bytes[k] = 8'hxx;
            got_waits[k] = -1;
        end
        for (int k = 0; k < n; k++) begin
            wait_tx_start(40, ok, b, w);
            if (!ok) break;
            got_bytes[k] = b;
            got_waits[k] = w;
            nfound++;
            tick(1);
            if (dbg.tx_bus !== b) stable = 1'b0;
            if (inject && k == 0) begin
                dbg.rx_bus       = CMD_STEP;
                dbg.rx_done_tick = 1'b1;
            end
            tick(1);
            dbg.rx_done_tick = 1'b0;
            if (dbg.tx_bus !== b) stable = 1'b0;
            dbg.tx_done_tick = 1'b1;
            tick(1);
            dbg.tx_done_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_checks++; if (dbg.Datapath_reset !== 1'b1) begin n_fail++; $display("FAIL reset_dp_reset: got %b expected 1", dbg.Datapath_reset); end
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dbg.busy); end
        n_checks++; if (dbg.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", dbg.tx_start); end
        n_checks++; if (dbg.tx_bus !== 8'h00) begin n_fail++; $display("FAIL reset_tx_bus: got %h expected 00", dbg.tx_bus); end
        n_checks++; if (dbg.Datapath_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en: got %b expected 0", dbg.Datapath_clk_en); end
        reset = 1'b0;
        tick(1);
        n_checks++; if (dbg.Datapath_reset !== 1'b0) begin n_fail++; $display("FAIL reset_release_dp_reset: got %b expected 0", dbg.Datapath_reset); end
        exp_cyc = 32'd0;
        $display("test_reset: done");
    endtask

    task automatic test_rst_cmd();
        int b_rst, b_busy, b_tx, b_en;
        b_rst = dp_rst_tot; b_busy = busy_tot; b_tx = tx_tot; b_en = clk_en_tot;
        send_cmd(CMD_RST);
        n_checks++; if (dbg.Datapath_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_dp_reset_rise: got %b expected 1", dbg.Datapath_reset); end
        n_checks++; if (dbg.busy !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_busy_rise: got %b expected 1", dbg.busy); end
        tick(8);
        n_checks++; if (dp_rst_tot - b_rst != 4) begin n_fail++; $display("FAIL rst_cmd_pulse_len: got %0d expected 4", dp_rst_tot - b_rst); end
        n_checks++; if (busy_tot - b_busy != 4) begin n_fail++; $display("FAIL rst_cmd_busy_len: got %0d expected 4", busy_tot - b_busy); end
        n_checks++; if (tx_tot - b_tx != 0) begin n_fail++; $display("FAIL rst_cmd_no_tx: got %0d expected 0", tx_tot - b_tx); end
        n_checks++; if (clk_en_tot - b_en != 0) begin n_fail++; $display("FAIL rst_cmd_no_clk_en: got %0d expected 0", clk_en_tot - b_en); end
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_busy_fall: got %b expected 0", dbg.busy); end
        exp_cyc = 32'd0;
        $display("test_rst_cmd: reset pulse %0d cycles", dp_rst_tot - b_rst);
    endtask

    task automatic test_step();
        int b_en, b_tx;
        dbg.DataPath_bus = 32'hA1B2C3D4;
        b_en = clk_en_tot; b_tx = tx_tot;
        send_cmd(CMD_STEP);
        n_checks++; if (dbg.Datapath_clk_en !== 1'b1) begin n_fail++; $display("FAIL step_clk_en: got %b expected 1", dbg.Datapath_clk_en); end
        n_checks++; if (dbg.busy !== 1'b1) begin n_fail++; $display("FAIL step_busy: got %b expected 1", dbg.busy); end
        exp_cyc = exp_cyc + 32'd1;
        collect_dump(NB, 1'b0);
        n_checks++; if (nfound != NB) begin n_fail++; $display("FAIL step_byte_count: got %0d expected %0d", nfound, NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got_bytes[k] !== exp_byte(32'hA1B2C3D4, exp_cyc, k)) begin
                n_fail++; $display("FAIL step_byte%0d: got %h expected %h", k, got_bytes[k], exp_byte(32'hA1B2C3D4, exp_cyc, k));
            end
            $display("test_step: byte %0d = %h", k, got_bytes[k]);
        end
        n_checks++; if (got_waits[0] != 2) begin n_fail++; $display("FAIL step_latency: got %0d expected 2", got_waits[0]); end
        n_checks++; if (got_waits[1] != 0) begin n_fail++; $display("FAIL step_gap: got %0d expected 0", got_waits[1]); end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL step_tx_bus_stable: got %b expected 1", stable); end
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL step_busy_fall: got %b expected 0", dbg.busy); end
        n_checks++; if (clk_en_tot - b_en != 1) begin n_fail++; $display("FAIL step_clk_en_cycles: got %0d expected 1", clk_en_tot - b_en); end
        n_checks++; if (tx_tot - b_tx != NB) begin n_fail++; $display("FAIL step_tx_starts: got %0d expected %0d", tx_tot - b_tx, NB); end
    endtask

    task automatic test_cont();
        int b_en, b_tx;
        send_cmd(CMD_RST);
        tick(6);
        exp_cyc = 32'd0;
        dbg.DataPath_bus = 32'hA1B2C3D4;
        dbg.halt = 1'b0;
        b_en = clk_en_tot; b_tx = tx_tot;
        send_cmd(CMD_CONT);
        tick(9);
        n_checks++; if (dbg.Datapath_clk_en !== 1'b1) begin n_fail++; $display("FAIL cont_running: got %b expected 1", dbg.Datapath_clk_en); end
        tick(1);
        dbg.halt = 1'b1;
        #1;
        n_checks++; if (dbg.Datapath_clk_en !== 1'b0) begin n_fail++; $display("FAIL cont_halt_gate: got %b expected 0", dbg.Datapath_clk_en); end
        exp_cyc = exp_cyc + 32'd10;
        collect_dump(NB, 1'b0);
        dbg.halt = 1'b0;
        n_checks++; if (clk_en_tot - b_en != 10) begin n_fail++; $display("FAIL cont_clk_en_cycles: got %0d expected 10", clk_en_tot - b_en); end
        n_checks++; if (nfound != NB) begin n_fail++; $display("FAIL cont_byte_count: got %0d expected %0d", nfound, NB); end
        n_checks++; if (got_waits[0] != 2) begin n_fail++; $display("FAIL cont_latency: got %0d expected 2", got_waits[0]); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got_bytes[k] !== exp_byte(32'hA1B2C3D4, exp_cyc, k)) begin
                n_fail++; $display("FAIL cont_byte%0d: got %h expected %h", k, got_bytes[k], exp_byte(32'hA1B2C3D4, exp_cyc, k));
            end
            $display("test_cont: byte %0d = %h", k, got_bytes[k]);
        end
        n_checks++; if (tx_tot - b_tx != NB) begin n_fail++; $display("FAIL cont_tx_starts: got %0d expected %0d", tx_tot - b_tx, NB); end
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy_fall: got %b expected 0", dbg.busy); end
    endtask

    task automatic test_drop();
        int b_en, b_tx;
        dbg.DataPath_bus = 32'h12345678;
        b_en = clk_en_tot; b_tx = tx_tot;
        send_cmd(CMD_STEP);
        exp_cyc = exp_cyc + 32'd1;
        collect_dump(NB, 1'b1);
        n_checks++; if (nfound != NB) begin n_fail++; $display("FAIL drop_byte_count: got %0d expected %0d", nfound, NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (got_bytes[k] !== exp_byte(32'h12345678, exp_cyc, k)) begin
                n_fail++; $display("FAIL drop_byte%0d: got %h expected %h", k, got_bytes[k], exp_byte(32'h12345678, exp_cyc, k));
            end
        end
        dbg.tx_done_tick = 1'b1;
        tick(1);
        dbg.tx_done_tick = 1'b0;
        tick(20);
        n_checks++; if (tx_tot - b_tx != NB) begin n_fail++; $display("FAIL drop_extra_bytes: got %0d expected %0d", tx_tot - b_tx, NB); end
        n_checks++; if (clk_en_tot - b_en != 1) begin n_fail++; $display("FAIL drop_clk_en_cycles: got %0d expected 1", clk_en_tot - b_en); end
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", dbg.busy); end
        $display("test_drop: %0d bytes sent", tx_tot - b_tx);
    endtask

    task automatic test_reset_abort();
        int         b_tx, w;
        bit         ok;
        logic [7:0] b;
        dbg.DataPath_bus = 32'hCAFEF00D;
        b_tx = tx_tot;
        send_cmd(CMD_STEP);
        collect_dump(1, 1'b0);
        n_checks++; if (got_bytes[0] !== 8'h0D) begin n_fail++; $display("FAIL abort_byte0: got %h expected 0d", got_bytes[0]); end
        wait_tx_start(10, ok, b, w);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_second_start: got %b expected 1", ok); end
        n_checks++; if (b !== 8'hF0) begin n_fail++; $display("FAIL abort_byte1: got %h expected f0", b); end
        reset = 1'b1;
        tick(1);
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", dbg.busy); end
        n_checks++; if (dbg.tx_start !== 1'b0) begin n_fail++; $display("FAIL abort_tx_start: got %b expected 0", dbg.tx_start); end
        n_checks++; if (dbg.Datapath_reset !== 1'b1) begin n_fail++; $display("FAIL abort_dp_reset: got %b expected 1", dbg.Datapath_reset); end
        n_checks++; if (dbg.tx_bus !== 8'h00) begin n_fail++; $display("FAIL abort_tx_bus: got %h expected 00", dbg.tx_bus); end
        tick(2);
        reset = 1'b0;
        tick(1);
        exp_cyc = 32'd0;
        for (int i = 0; i < 3; i++) begin
            dbg.tx_done_tick = 1'b1;
            tick(1);
            dbg.tx_done_tick = 1'b0;
            tick(3);
        end
        tick(10);
        n_checks++; if (tx_tot - b_tx != 2) begin n_fail++; $display("FAIL abort_total_bytes: got %0d expected 2", tx_tot - b_tx); end
        n_checks++; if (dbg.Datapath_reset !== 1'b0) begin n_fail++; $display("FAIL abort_dp_reset_release: got %b expected 0", dbg.Datapath_reset); end
        $display("test_reset_abort: %0d bytes started before abort", tx_tot - b_tx);
    endtask

    task automatic test_bad_cmd();
        int b_busy, b_tx, b_rst, b_en;
        b_busy = busy_tot; b_tx = tx_tot; b_rst = dp_rst_tot; b_en = clk_en_tot;
        send_cmd(8'h41);
        n_checks++; if (dbg.busy !== 1'b0) begin n_fail++; $display("FAIL bad_cmd_busy: got %b expected 0", dbg.busy); end
        tick(10);
        n_checks++; if (busy_tot - b_busy != 0) begin n_fail++; $display("FAIL bad_cmd_busy_cycles: got %0d expected 0", busy_tot - b_busy); end
        n_checks++; if (tx_tot - b_tx != 0) begin n_fail++; $display("FAIL bad_cmd_tx: got %0d expected 0", tx_tot - b_tx); end
        n_checks++; if (dp_rst_tot - b_rst != 0) begin n_fail++; $display("FAIL bad_cmd_dp_reset: got %0d expected 0", dp_rst_tot - b_rst); end
        n_checks++; if (clk_en_tot - b_en != 0) begin n_fail++; $display("FAIL bad_cmd_clk_en: got %0d expected 0", clk_en_tot - b_en); end
        $display("test_bad_cmd: 0x41 ignored check done");
    endtask

    initial begin
        reset            = 1'b1;
        dbg.rx_done_tick = 1'b0;
        dbg.rx_bus       = 8'h00;
        dbg.tx_done_tick = 1'b0;
        dbg.DataPath_bus = 32'h0;
        dbg.halt         = 1'b0;
        exp_cyc          = 32'd0;
        #1;
        test_reset();
        test_rst_cmd();
        test_step();
        test_cont();
        test_drop();
        test_reset_abort();
        test_bad_cmd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
